c5g_housekeeping_gpio_ctrl: RTL and testbench
=============================================

C5G_HOUSEKEEPING_GPIO_CTRL -- requirements
Module: c5g_housekeeping_gpio_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 8: port width, 1..32.
- RESET_VALUE, 0: out_port value after reset.
- PULSE_CYCLES, 1000: pulse high time in clk cycles, >=1.
- EDGE_TYPE, 0: edge captured; 0 rising, 1 falling, 2 any.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- address  in  3  Avalon-MM word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH-1 ignored.
- readdata  out  32  read data; bits above WIDTH-1 read 0.
- in_port  in  WIDTH  asynchronous input pins.
- out_port  out  WIDTH  registered output pins.
- irq  out  1  level interrupt.

Function
REQ-003 A write SHALL occur when chipselect=1 and write_n=0; at most one register is written per cycle.
REQ-004 readdata SHALL be combinational from address, with zero wait states and zero read latency; unmapped addresses SHALL read 0.
REQ-005 Address 0 DATA (RW): a write sets out_reg <= writedata; a read returns out_reg.
REQ-006 Address 1 INPUT (RO): a read returns the synchronised input sync2.
REQ-007 Address 2 IRQMASK (RW): per-bit interrupt enable.
REQ-008 Address 3 EDGECAP (R/W1C): a write clears the bits written as 1.
REQ-009 Address 4 OUTSET (WO): out_reg |= writedata.
REQ-010 Address 5 OUTCLEAR (WO): out_reg &= ~writedata.
REQ-011 Address 6 PULSE (W): start a pulse on the masked bits; a read returns pulse_mask.
REQ-012 out_port SHALL equal out_reg, with no combinational path from the bus.
REQ-013 in_port SHALL pass through two flops (sync1, sync2); sync2 is then registered into prev.
REQ-014 Edge detection: rising = sync2 & ~prev; falling = ~sync2 & prev; any = sync2 ^ prev, selected by EDGE_TYPE.
REQ-015 A detected edge SHALL set its EDGECAP bit the cycle after it appears on sync2; a pin edge reaches EDGECAP in 3-4 clk cycles.
REQ-016 If an edge set and a W1C clear hit the same bit in the same cycle, set SHALL win.
REQ-017 irq SHALL equal |(edgecap & irqmask), derived from registers only.
REQ-018 The pulse engine SHALL have states IDLE and ACTIVE, a down-counter cnt of width clog2(PULSE_CYCLES)+1, and a pulse_mask register.
REQ-019 PULSE write with a nonzero mask m:
- out_reg |= m; pulse_mask |= m; cnt <= PULSE_CYCLES-1; state ACTIVE.
- A write while ACTIVE restarts cnt for all pulsing bits.
REQ-020 PULSE write with mask 0 SHALL have no effect.
REQ-021 ACTIVE with cnt>0: decrement cnt each cycle.
REQ-022 ACTIVE with cnt=0: out_reg &= ~pulse_mask; pulse_mask <= 0; state IDLE.
REQ-023 Pulsed bits SHALL be high on out_port for exactly PULSE_CYCLES cycles.
REQ-024 A DATA, OUTSET or OUTCLEAR write touching a bit (DATA: any bit; SET/CLEAR: bits written 1) SHALL remove that bit from pulse_mask and apply the write; if pulse_mask becomes 0, state SHALL go IDLE.
REQ-025 If a bus write coincides with the expiry cycle, the bus write SHALL take precedence on the bits it touches; expiry SHALL clear only the remaining bits.

Reset
REQ-026 With reset_n=0 at a clk edge, the block SHALL set:
- out_reg = RESET_VALUE.
- irqmask, edgecap and pulse_mask = 0.
- cnt = 0; state IDLE.
- sync1, sync2 and prev = 0.
REQ-027 Reset asserted mid-pulse SHALL abort the pulse, and out_port SHALL equal RESET_VALUE on the next cycle.
REQ-028 Reset SHALL have no asynchronous effect.

Verification
REQ-029 Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, irq=0, readdata at address 6 = 0.
REQ-030 DATA=8'h0F, then OUTSET 8'h30, then OUTCLEAR 8'h03 -> out_port=8'h3C; reading address 0 returns 32'h3C.
REQ-031 PULSE_CYCLES=4, PULSE 8'h01 at cycle t -> out_port[0]=1 for cycles t+1..t+4 and 0 at t+5; address 6 reads 0 after expiry.
REQ-032 PULSE 8'h01, then PULSE 8'h02 two cycles later -> both bits drop together 4 cycles after the second write; OUTCLEAR 8'h01 mid-pulse -> bit 0 drops immediately and bit 1 still expires.
REQ-033 EDGE_TYPE=0, IRQMASK=8'h04, in_port[2] rises -> EDGECAP[2]=1 and irq=1 within 4 cycles; W1C 8'h04 -> irq=0; an edge coinciding with the W1C leaves EDGECAP[2]=1.
REQ-034 reset_n=0 for 1 cycle mid-pulse -> out_port=RESET_VALUE, state IDLE, and no residual clear after release.

Source files
------------

// File: rtl/c5g_housekeeping_gpio_ctrl.sv
// c5g_housekeeping_gpio_ctrl
// Avalon-MM GPIO block. It has a registered output port and a synchronised input port.
// It captures input edges into an interrupt, and it can pulse output bits for a fixed
// number of clock cycles.
//
// Ports:
//   clk          sole clock, rising edge
//   reset_n      synchronous active-low reset
//   address      word address: 0 DATA, 1 INPUT, 2 IRQMASK, 3 EDGECAP (W1C),
//                4 OUTSET, 5 OUTCLEAR, 6 PULSE
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data, bits above WIDTH-1 ignored
//   readdata     combinational read data, zero-extended
//   in_port      asynchronous input pins
//   out_port     registered output pins
//   irq          level interrupt, |(edgecap & irqmask)
module c5g_housekeeping_gpio_ctrl #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int unsigned      PULSE_CYCLES = 1000,
    parameter int unsigned      EDGE_TYPE    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int unsigned      CNT_W    = $clog2(PULSE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_INPUT   = 3'd1;
    localparam logic [2:0] A_IRQMASK = 3'd2;
    localparam logic [2:0] A_EDGECAP = 3'd3;
    localparam logic [2:0] A_OUTSET  = 3'd4;
    localparam logic [2:0] A_OUTCLR  = 3'd5;
    localparam logic [2:0] A_PULSE   = 3'd6;

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] pmask_q, pmask_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wd;
    logic             wr_en;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0)      edge_det = sync2_q & ~prev_q;
        else if (EDGE_TYPE == 1) edge_det = ~sync2_q & prev_q;
        else                     edge_det = sync2_q ^ prev_q;
    end

    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q & ~((wr_en && address == A_EDGECAP) ? wd : '0);
        // A new edge is ORed in after the W1C clear, so an edge set wins over a clear.
        edgecap_d = edgecap_d | edge_det;
        if (wr_en && address == A_IRQMASK) irqmask_d = wd;
    end

    // Pulse expiry is applied first. Any bus write is then layered on top of it.
    // As a result, a coincident write wins on the bits that it touches.
    always_comb begin
        out_d   = out_q;
        pmask_d = pmask_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (state_q == ACTIVE) begin
            if (cnt_q == '0) begin
                out_d   = out_q & ~pmask_q;
                pmask_d = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        if (wr_en) begin
            case (address)
                A_DATA: begin
                    out_d   = wd;
                    pmask_d = '0;
                end
                A_OUTSET: begin
                    out_d   = out_d | wd;
                    pmask_d = pmask_d & ~wd;
                end
                A_OUTCLR: begin
                    out_d   = out_d & ~wd;
                    pmask_d = pmask_d & ~wd;
                end
                A_PULSE: begin
                    if (wd != '0) begin
                        out_d   = out_d | wd;
                        pmask_d = pmask_d | wd;
                        cnt_d   = CNT_LOAD;
                        state_d = ACTIVE;
                    end
                end
                default: ;
            endcase
        end
        if (pmask_d == '0) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_q     <= RESET_VALUE;
            pmask_q   <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            pmask_q   <= pmask_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:    readdata[WIDTH-1:0] = out_q;
            A_INPUT:   readdata[WIDTH-1:0] = sync2_q;
            A_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
            A_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            A_PULSE:   readdata[WIDTH-1:0] = pmask_q;
            default:   readdata = '0;
        endcase
    end

    assign out_port = out_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_c5g_housekeeping_gpio_ctrl.sv
// Self-checking bench for c5g_housekeeping_gpio_ctrl.
// The bench is configured with WIDTH=8, RESET_VALUE=8'hA5, PULSE_CYCLES=4 and rising-edge capture.
module tb_c5g_housekeeping_gpio_ctrl;

    localparam int unsigned P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  addr = '0;
    logic        cs = 1'b0;
    logic        wn = 1'b1;
    logic [31:0] wd = '0;
    logic [31:0] readdata;
    logic [7:0]  pins = '0;
    logic [7:0]  out_port;
    logic        irq;

    int unsigned errs = 0;
    int unsigned checks = 0;

    c5g_housekeeping_gpio_ctrl #(
        .WIDTH(8), .RESET_VALUE(8'hA5), .PULSE_CYCLES(P), .EDGE_TYPE(0)
    ) dut (
        .clk(clk), .reset_n(rst_n), .address(addr), .chipselect(cs),
        .write_n(wn), .writedata(wd), .readdata(readdata),
        .in_port(pins), .out_port(out_port), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model. Each pulse is tracked by the absolute cycle number at which
    // its bits must drop, not by a counter.
    logic [7:0]  m_out = '0, m_pb = '0, m_im = '0, m_cap = '0;
    logic [7:0]  m_s1 = '0, m_s2 = '0, m_prev = '0;
    int unsigned cyc = 0, m_deadline = 0;

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        case (a)
            3'd0:    return {24'h0, m_out};
            3'd1:    return {24'h0, m_s2};
            3'd2:    return {24'h0, m_im};
            3'd3:    return {24'h0, m_cap};
            3'd6:    return {24'h0, m_pb};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [7:0] edg, w;
        logic       wen;
        cyc++;
        if (!rst_n) begin
            m_out = 8'hA5; m_pb = '0; m_im = '0; m_cap = '0;
            m_s1 = '0; m_s2 = '0; m_prev = '0;
        end else begin
            edg = m_s2 & ~m_prev;
            m_prev = m_s2; m_s2 = m_s1; m_s1 = pins;
            wen = cs && !wn;
            w = wd[7:0];
            m_cap = (m_cap & ~((wen && addr == 3'd3) ? w : 8'h00)) | edg;
            if (m_pb != 0 && cyc == m_deadline) begin
                m_out &= ~m_pb;
                m_pb = '0;
            end
            if (wen) begin
                case (addr)
                    3'd0: begin m_out = w; m_pb = '0; end
                    3'd2: m_im = w;
                    3'd4: begin m_out |= w; m_pb &= ~w; end
                    3'd5: begin m_out &= ~w; m_pb &= ~w; end
                    3'd6: if (w != 0) begin
                        m_out |= w; m_pb |= w; m_deadline = cyc + P;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_out", {24'h0, out_port}, {24'h0, m_out});
        check("model_irq", {31'h0, irq}, {31'h0, |(m_cap & m_im)});
        check("model_rd", readdata, model_rd(addr));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wn = 1'b0; addr = a; wd = d;
        tick();
        cs = 1'b0; wn = 1'b1; wd = '0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, readdata, exp);
    endtask

    typedef struct {
        logic        rst_n;
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        logic        exp_irq;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        vt[0] = '{1'b0, 1'b0, 1'b1, 3'd6, 32'h0,         8'hA5, 1'b0, 32'h00};
        vt[1] = '{1'b1, 1'b1, 1'b0, 3'd0, 32'h0F,        8'h0F, 1'b0, 32'h0F};
        vt[2] = '{1'b1, 1'b1, 1'b0, 3'd4, 32'h30,        8'h3F, 1'b0, 32'h00};
        vt[3] = '{1'b1, 1'b1, 1'b0, 3'd5, 32'h03,        8'h3C, 1'b0, 32'h00};
        vt[4] = '{1'b1, 1'b1, 1'b1, 3'd0, 32'h0,         8'h3C, 1'b0, 32'h3C};
        vt[5] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'hFF,        8'h3C, 1'b0, 32'hFF};
        vt[6] = '{1'b1, 1'b1, 1'b1, 3'd7, 32'h0,         8'h3C, 1'b0, 32'h00};
        vt[7] = '{1'b1, 1'b1, 1'b0, 3'd0, 32'hFFFF_FF12, 8'h12, 1'b0, 32'h12};
        vt[8] = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h55,        8'h12, 1'b0, 32'h12};
        vt[9] = '{1'b1, 1'b1, 1'b1, 3'd1, 32'h0,         8'h12, 1'b0, 32'h00};

        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rst_n = vt[i].rst_n; cs = vt[i].cs; wn = vt[i].wn;
            addr = vt[i].addr; wd = vt[i].wd;
            tick();
            check($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vt[i].exp_out});
            check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vt[i].exp_irq});
            check($sformatf("vec%0d_rd", i), readdata, vt[i].exp_rd);
        end
        cs = 1'b0; wn = 1'b1; wd = '0;

        // Single pulse: high for exactly P cycles, then address 6 reads back zero.
        wr(3'd0, 32'h0);
        wr(3'd6, 32'h01);
        for (int i = 0; i < 4; i++) begin
            check("pulse_high", {31'h0, out_port[0]}, 32'h1);
            if (i < 3) tick();
        end
        tick();
        check("pulse_low", {31'h0, out_port[0]}, 32'h0);
        rd_check("pulse_mask_cleared", 3'd6, 32'h0);

        // A second pulse write restarts the count for both bits.
        wr(3'd6, 32'h01);
        tick();
        wr(3'd6, 32'h02);
        check("restart_both", {24'h0, out_port}, 32'h03);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("restart_hold", {24'h0, out_port}, 32'h03);
        end
        tick();
        check("restart_drop", {24'h0, out_port}, 32'h00);

        // OUTCLEAR during a pulse removes bit 0 at once. Bit 1 still expires on schedule.
        wr(3'd6, 32'h03);
        wr(3'd5, 32'h01);
        check("clr_mid_out", {24'h0, out_port}, 32'h02);
        rd_check("clr_mid_mask", 3'd6, 32'h02);
        tick();
        check("clr_mid_hold1", {24'h0, out_port}, 32'h02);
        tick();
        check("clr_mid_hold2", {24'h0, out_port}, 32'h02);
        tick();
        check("clr_mid_expire", {24'h0, out_port}, 32'h00);

        // Rising edge on pin 2 raises irq. W1C clears it. An edge that coincides with W1C survives.
        wr(3'd2, 32'h04);
        pins = 8'h04;
        got = 1'b0;
        for (int n = 0; n < 4 && !got; n++) begin
            tick();
            if (irq) got = 1'b1;
        end
        check("edge_irq_within_4", {31'h0, got}, 32'h1);
        rd_check("edgecap_set", 3'd3, 32'h04);
        wr(3'd3, 32'h04);
        check("w1c_irq_low", {31'h0, irq}, 32'h0);
        pins = 8'h00;
        for (int n = 0; n < 3; n++) tick();
        pins = 8'h04;
        tick();
        tick();
        wr(3'd3, 32'h04);
        check("set_beats_w1c_irq", {31'h0, irq}, 32'h1);
        rd_check("set_beats_w1c_cap", 3'd3, 32'h04);
        wr(3'd3, 32'h04);

        // Reset during a pulse: the output is RESET_VALUE and no stale expiry clears bit 0 afterwards.
        wr(3'd0, 32'h00);
        wr(3'd6, 32'h01);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_out", {24'h0, out_port}, 32'hA5);
        rd_check("rst_mid_mask", 3'd6, 32'h0);
        for (int n = 0; n < 6; n++) begin
            tick();
            check("rst_no_residual", {24'h0, out_port}, 32'hA5);
        end

        // Random traffic, checked against the model on every cycle.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            cs    = ($urandom_range(0, 3) != 0);
            wn    = ($urandom_range(0, 1) != 0);
            addr  = ($urandom_range(0, 2) == 0) ? 3'd6 : 3'($urandom_range(0, 7));
            wd    = ($urandom_range(0, 1) != 0) ? $urandom : {24'h0, 8'(1 << $urandom_range(0, 7))};
            if ($urandom_range(0, 3) == 0) pins = pins ^ 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
